muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource used by MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO.
- Accepts one operation from the EX stage.
- Runs a fixed-latency multiplier path or a 32-iteration restoring divider.
- Owns the HI/LO registers.
- Drives a pipeline stall until the result is committed.
- Sits beside the ALU in EX; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (legal 1..8); models the pipelined multiplier delay.
- HILO_RST, 32'h0, reset value of HI and LO.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  EX holds a valid muldiv op (level, held while stalled)
- op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11-15 treated as none
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/ERET cancel of the EX instruction
- stall  out  1  hold IF/ID/EX
- done  out  1  one-cycle pulse when HI/LO committed by a multicycle op
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock and reset: one clock `clk`. `resetn` is asynchronous, active-low. On reset: state=IDLE, hi=lo=HILO_RST, done=0, internal counter=0. `stall` is combinational and reads 0 while in reset.
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with start=1, flush=0 and op in 1..10. Acceptance happens at the clock edge.
- MTHI/MTLO:
  - hi (or lo) <= src_a at the accept edge.
  - State stays IDLE; stall=0, done=0.
- Multiply ops (1,2,5,6,7,8):
  - Operands are latched at accept; state goes to MUL; counter=MUL_LAT-1.
  - MUL decrements the counter each cycle; counter==0 -> DONE.
  - Product is 64-bit, signed for 1/5/7 and unsigned for 2/6/8.
  - MADD*: {hi,lo} + product. MSUB*: {hi,lo} - product. Both are mod 2^64 using {hi,lo} as sampled at DONE.
- Divide ops (3,4):
  - At accept: latch |a| and |b| (signed) or a and b (unsigned), plus quotient sign = a[31]^b[31] and remainder sign = a[31]. State goes to DIV; counter=31.
  - One restoring iteration per cycle; after the counter==0 iteration -> DONE.
  - Signed results are negated to match the latched signs.
  - Divisor==0: lo=32'hFFFFFFFF, hi=src_a. Latency is unchanged.
- DONE: hi/lo written at the edge leaving DONE; done=1 during DONE; next state IDLE. start is ignored while in DONE.
- Latency from the accept edge:
  - Multiply: done high in cycle MUL_LAT+1.
  - Divide: done high in cycle 33.
- stall = (IDLE & start & !flush & op is multiply/divide) | MUL | DIV. stall=0 in DONE, so EX advances at the DONE edge.
- flush in any state:
  - Next state IDLE; no HI/LO write; done=0.
  - stall drops combinationally in the same cycle.
  - A flush in IDLE blocks acceptance, including MTHI/MTLO.
- start deasserting mid-operation has no effect; only flush cancels an accepted op.
- Op 0 or 11-15: no action, stall=0.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro MULDIV_DIV_BYPASS_EN.
- When defined, a divide takes DIV -> DONE after one cycle (done in cycle 2) in either of these cases:
  - Divisor==0: same result values as without the macro.
  - |dividend| < |divisor| (magnitudes for signed, raw values for unsigned): lo=0, hi=src_a.
- When undefined, every divide takes the full 32 iterations.

Test Plan:
- MULT a=32'hFFFFFFFF, b=2, MUL_LAT=2 -> stall high 3 cycles (accept, MUL, MUL); done in cycle 3; hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> done in cycle 33; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU of the same operands -> lo=32'h7FFFFFFC, hi=1.
- DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7. With MULDIV_DIV_BYPASS_EN: done in cycle 2; also DIVU a=3, b=9 -> lo=0, hi=3 in cycle 2.
- MTLO 5, MTHI 0, then MADD a=3, b=4 -> lo=32'h11, hi=0. Then MSUBU a=1, b=32'h12 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFF.
- DIV accepted, flush=1 at cycle 10 -> stall=0 that cycle, done never pulses, hi/lo unchanged. A new MULT accepted the next cycle completes normally.
- MTHI src_a=32'h1234 -> hi=32'h1234 the next cycle, stall never asserted. resetn low during MUL -> hi=lo=HILO_RST, stall=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the HI/LO multiply/divide resource.
//
// Handles MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO coming from EX.
// Multiplies use a fixed-latency path of MUL_LAT cycles. Divides use a
// 32-iteration restoring divider. The block owns HI/LO and stalls the front of
// the pipeline until a multicycle result has been committed.
//
// Ports:
//   clk      system clock
//   resetn   asynchronous active-low reset
//   start    EX holds a valid muldiv op (level, held while stalled)
//   op       0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU,
//            7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11-15 none
//   src_a    rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b    rt operand (divisor / multiplier)
//   flush    cancels the EX instruction and any op in flight
//   stall    hold IF/ID/EX (combinational)
//   done     one-cycle pulse while HI/LO are being committed
//   hi, lo   HI/LO registers (read directly by MFHI/MFLO)
//
// Optional feature: define MULDIV_DIV_BYPASS_EN to finish a divide after one
// DIV cycle when the divisor is zero or |dividend| < |divisor|.

module muldiv_ctrl #(
    parameter int unsigned MUL_LAT  = 2,
    parameter logic [31:0] HILO_RST = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;

    // Decoded op
    logic        is_mul;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic        mul_signed;
    logic        div_signed;
    logic        accept;

    // Multiplier datapath
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [3:0]  mul_op;
    logic [63:0] product;
    logic [63:0] mul_res;

    // Divider datapath
    logic        res_is_div;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_b;
    logic [31:0] div_a_raw;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_last;
`ifdef MULDIV_DIV_BYPASS_EN
    logic        div_small;
`endif

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    always_comb begin
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_mthi    = 1'b0;
        is_mtlo    = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        case (op)
            OP_MULT, OP_MADD, OP_MSUB: begin
                is_mul     = 1'b1;
                mul_signed = 1'b1;
            end
            OP_MULTU, OP_MADDU, OP_MSUBU: is_mul = 1'b1;
            OP_DIV: begin
                is_div     = 1'b1;
                div_signed = 1'b1;
            end
            OP_DIVU: is_div  = 1'b1;
            OP_MTHI: is_mthi = 1'b1;
            OP_MTLO: is_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign accept = (state == S_IDLE) && start && !flush;

    // Stall is gated by resetn so it reads low while reset is asserted even
    // if EX is presenting a multicycle op.
    assign stall = resetn && !flush &&
                   ((accept && (is_mul || is_div)) ||
                    (state == S_MUL) || (state == S_DIV));

    assign done = (state == S_DONE) && !flush;

    // ------------------------------------------------------------------
    // Operand preparation for divide
    // ------------------------------------------------------------------
    assign a_neg = div_signed && src_a[31];
    assign b_neg = div_signed && src_b[31];
    assign mag_a = a_neg ? -src_a : src_a;
    assign mag_b = b_neg ? -src_b : src_b;

    // ------------------------------------------------------------------
    // Multiplier: operands are held sign/zero-extended to 64 bits so that a
    // plain 64-bit product is the correct result mod 2^64 for both kinds.
    // ------------------------------------------------------------------
    assign product = mul_a * mul_b;

    always_comb begin
        mul_res = product;
        case (mul_op)
            OP_MADD, OP_MADDU: mul_res = {hi, lo} + product;
            OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - product;
            default:           mul_res = product;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divider step: shift remainder/quotient pair left by one and
    // subtract the divisor if it fits.
    // ------------------------------------------------------------------
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, div_b};

    assign q_fin = q_neg ? -quo : quo;
    assign r_fin = r_neg ? -rem : rem;

    always_comb begin
        div_hi = r_fin;
        div_lo = q_fin;
        if (div_zero) begin
            div_hi = div_a_raw;
            div_lo = '1;
        end
`ifdef MULDIV_DIV_BYPASS_EN
        else if (div_small) begin
            div_hi = div_a_raw;
            div_lo = '0;
        end
`endif
    end

`ifdef MULDIV_DIV_BYPASS_EN
    assign div_last = (cnt == 5'd0) || div_zero || div_small;
`else
    assign div_last = (cnt == 5'd0);
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_mul) begin
                        state_nxt = S_MUL;
                    end else if (start && is_div) begin
                        state_nxt = S_DIV;
                    end
                end
                S_MUL:   if (cnt == 5'd0) state_nxt = S_DONE;
                S_DIV:   if (div_last)    state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi         <= HILO_RST;
            lo         <= HILO_RST;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_op     <= '0;
            res_is_div <= 1'b0;
            quo        <= '0;
            rem        <= '0;
            div_b      <= '0;
            div_a_raw  <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
`ifdef MULDIV_DIV_BYPASS_EN
            div_small  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mthi) hi <= src_a;
                        if (is_mtlo) lo <= src_a;
                        if (is_mul) begin
                            mul_a      <= {{32{mul_signed & src_a[31]}}, src_a};
                            mul_b      <= {{32{mul_signed & src_b[31]}}, src_b};
                            mul_op     <= op;
                            res_is_div <= 1'b0;
                            cnt        <= 5'(MUL_LAT - 1);
                        end
                        if (is_div) begin
                            quo        <= mag_a;
                            rem        <= '0;
                            div_b      <= mag_b;
                            div_a_raw  <= src_a;
                            q_neg      <= a_neg ^ b_neg;
                            r_neg      <= a_neg;
                            div_zero   <= (src_b == '0);
`ifdef MULDIV_DIV_BYPASS_EN
                            div_small  <= (mag_a < mag_b);
`endif
                            res_is_div <= 1'b1;
                            cnt        <= 5'd31;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                S_DIV: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                S_DONE: begin
                    cnt <= '0;
                    if (!flush) begin
                        if (res_is_div) begin
                            hi <= div_hi;
                            lo <= div_lo;
                        end else begin
                            hi <= mul_res[63:32];
                            lo <= mul_res[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a table of directed ops applied in
// order (HI/LO state carries from one row to the next), then hand-written
// sequences for flush, flush-in-IDLE and reset during a multiply.

module tb_muldiv_ctrl;

    localparam logic [31:0] RSTV = 32'hA5A5_0001;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 33;
`ifdef MULDIV_DIV_BYPASS_EN
    localparam int LAT_BYP = 2;
`else
    localparam int LAT_BYP = 33;
`endif

    logic        clk;
    logic        resetn;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    muldiv_ctrl #(
        .MUL_LAT (2),
        .HILO_RST(RSTV)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one op in the IDLE cycle, hold start while stalled, measure the
    // cycle of the done pulse (0 = never) and check HI/LO afterwards.
    task automatic run_vec(input vec_t v, input int idx);
        int got;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b0;
        op    = v.op;
        src_a = v.a;
        src_b = v.b;
        #1;
        chk($sformatf("v%0d_stall_accept", idx), 64'(stall), 64'(v.lat != 0));
        @(posedge clk);
        got = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = cyc;
                break;
            end
            if (v.lat == 0) break;
            chk($sformatf("v%0d_stall_busy_c%0d", idx, cyc), 64'(stall), 64'(1));
        end
        if (got != 0) chk($sformatf("v%0d_stall_done", idx), 64'(stall), 64'(0));
        start = 1'b0;
        op    = 4'd0;
        chk($sformatf("v%0d_latency", idx), 64'(got), 64'(v.lat));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_done_low", idx), 64'(done), 64'(0));
        chk($sformatf("v%0d_hi", idx), 64'(hi), 64'(v.hi));
        chk($sformatf("v%0d_lo", idx), 64'(lo), 64'(v.lo));
    endtask

    initial begin
        vec_t fv;
        n_cmp = 0;
        n_err = 0;

        //            op     a             b             hi            lo            lat
        vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, LAT_MUL};
        vecs[2]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, LAT_DIV};
        vecs[3]  = '{4'd4,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, LAT_DIV};
        vecs[4]  = '{4'd4,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, LAT_BYP};
        vecs[5]  = '{4'd4,  32'h00000003, 32'h00000009, 32'h00000003, 32'h00000000, LAT_BYP};
        vecs[6]  = '{4'd10, 32'h00000005, 32'h0000BEEF, 32'h00000003, 32'h00000005, 0};
        vecs[7]  = '{4'd9,  32'h00000000, 32'h0000BEEF, 32'h00000000, 32'h00000005, 0};
        vecs[8]  = '{4'd5,  32'h00000003, 32'h00000004, 32'h00000000, 32'h00000011, LAT_MUL};
        vecs[9]  = '{4'd8,  32'h00000001, 32'h00000012, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL};
        vecs[10] = '{4'd9,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 0};
        vecs[11] = '{4'd3,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, LAT_DIV};
        vecs[12] = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, LAT_DIV};
        vecs[13] = '{4'd7,  32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h80000003, LAT_MUL};
        vecs[14] = '{4'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000004, LAT_MUL};
        vecs[15] = '{4'd3,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, LAT_BYP};
        vecs[16] = '{4'd1,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT_MUL};
        vecs[17] = '{4'd0,  32'h11111111, 32'h22222222, 32'h40000000, 32'h00000000, 0};
        vecs[18] = '{4'd12, 32'h11111111, 32'h22222222, 32'h40000000, 32'h00000000, 0};

        // Reset with a multiply presented: stall must read low in reset.
        resetn = 1'b0;
        start  = 1'b1;
        op     = 4'd1;
        src_a  = 32'd5;
        src_b  = 32'd6;
        flush  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_done",  64'(done),  64'(0));
        chk("rst_hi",    64'(hi),    64'(RSTV));
        chk("rst_lo",    64'(lo),    64'(RSTV));
        start  = 1'b0;
        op     = 4'd0;
        resetn = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // Flush a divide at cycle 10; then a MULT accepted the next cycle.
        @(negedge clk);
        start = 1'b1;
        op    = 4'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        #1;
        chk("fl_stall_accept", 64'(stall), 64'(1));
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 10) flush = 1'b1;
            #1;
            chk($sformatf("fl_done_c%0d", cyc), 64'(done), 64'(0));
            chk($sformatf("fl_stall_c%0d", cyc), 64'(stall), 64'(cyc != 10));
        end
        chk("fl_hi_kept", 64'(hi), 64'(32'h40000000));
        chk("fl_lo_kept", 64'(lo), 64'(32'h00000000));
        fv = '{4'd1, 32'd5, 32'd6, 32'h00000000, 32'h0000001E, LAT_MUL};
        run_vec(fv, 100);

        // Flush in IDLE blocks acceptance of both multicycle ops and MTHI.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 4'd1;
        #1;
        chk("fli_stall_mult", 64'(stall), 64'(0));
        @(negedge clk);
        op    = 4'd9;
        src_a = 32'hDEAD;
        #1;
        chk("fli_stall_mthi", 64'(stall), 64'(0));
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        op    = 4'd0;
        #1;
        chk("fli_stall_after", 64'(stall), 64'(0));
        chk("fli_hi", 64'(hi), 64'(32'h00000000));
        chk("fli_lo", 64'(lo), 64'(32'h0000001E));

        // Reset asserted during MUL.
        @(negedge clk);
        start = 1'b1;
        op    = 4'd1;
        src_a = 32'd3;
        src_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rm_stall_mul", 64'(stall), 64'(1));
        resetn = 1'b0;
        #1;
        chk("rm_stall", 64'(stall), 64'(0));
        chk("rm_hi", 64'(hi), 64'(RSTV));
        chk("rm_lo", 64'(lo), 64'(RSTV));
        @(negedge clk);
        start  = 1'b0;
        op     = 4'd0;
        resetn = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rm_idle_done_c%0d", cyc), 64'(done), 64'(0));
            chk($sformatf("rm_idle_stall_c%0d", cyc), 64'(stall), 64'(0));
        end
        chk("rm_hi_after", 64'(hi), 64'(RSTV));
        chk("rm_lo_after", 64'(lo), 64'(RSTV));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
